// File: rtl/fir_mac_engine.sv
// Time-multiplexed FIR multiply-accumulate stage.
// Holds a NUM_TAPS-deep sample delay line and runs one MAC per tap. Coefficients
// come from an external RAM port with 1-cycle read latency; the accumulate
// pipeline therefore trails the read issue by one cycle (idx_d, rd_d).
module fir_mac_engine #(
  parameter int unsigned DATA_WIDTH  = 3,
  parameter int unsigned COEFF_WIDTH = 16,
  parameter int unsigned NUM_TAPS    = 10,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned COEFF_BASE  = 0,
  parameter int unsigned ACC_WIDTH   = 23
) (
  input  logic                          iClk12M,
  input  logic                          iRst,
  input  logic                          iEnSample,
  input  logic signed [DATA_WIDTH-1:0]  iFirIn,
  output logic signed [DATA_WIDTH-1:0]  oCascOut,
  output logic                          oCoeffRd,
  output logic [ADDR_WIDTH-1:0]         oCoeffAddr,
  input  logic signed [COEFF_WIDTH-1:0] iCoeffData,
  output logic signed [ACC_WIDTH-1:0]   oMac,
  output logic                          oMacValid,
  output logic                          oBusy,
  output logic                          oOverrun
);

  localparam int unsigned PW = DATA_WIDTH + COEFF_WIDTH;
  localparam int unsigned IW = $clog2(NUM_TAPS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                       state, state_nxt;
  logic [IW-1:0]                idx, idx_d;
  logic                         rd_d;
  logic signed [DATA_WIDTH-1:0] dly [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0]  acc, acc_sum, mac_q;
  logic signed [PW-1:0]         prod;
  logic                         accept, last_tap, overrun_q;

  assign accept   = iEnSample && ((state == IDLE) || (state == DONE));
  assign last_tap = (idx == IW'(NUM_TAPS - 1));
  assign prod     = PW'(dly[idx_d]) * PW'(iCoeffData);
  assign acc_sum  = acc + ACC_WIDTH'(prod);

  assign oCascOut = dly[NUM_TAPS-1];
  assign oMac     = mac_q;
  assign oOverrun = overrun_q;

  // State register
  always_ff @(posedge iClk12M) begin
    if (iRst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; a strobe in DONE restarts immediately
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_tap) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs: RAM read port, valid pulse, busy
  always_comb begin
    oCoeffRd   = 1'b0;
    oCoeffAddr = '0;
    oMacValid  = 1'b0;
    oBusy      = (state != IDLE);
    if (state == RUN) begin
      oCoeffRd   = 1'b1;
      oCoeffAddr = ADDR_WIDTH'(COEFF_BASE) + ADDR_WIDTH'(idx);
    end
    if (state == DONE) oMacValid = 1'b1;
  end

  // Delay line, tap counter, accumulator, result and overrun flag
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++) dly[k] <= '0;
      idx       <= '0;
      idx_d     <= '0;
      rd_d      <= 1'b0;
      acc       <= '0;
      mac_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      rd_d  <= (state == RUN);
      idx_d <= idx;
      if (accept) begin
        dly[0] <= iFirIn;
        for (int unsigned k = 1; k < NUM_TAPS; k++) dly[k] <= dly[k-1];
        acc <= '0;
        idx <= '0;
      end else begin
        if (state == RUN) idx <= idx + IW'(1);
        // rd_d marks a cycle whose iCoeffData answers last cycle's read
        if (rd_d) acc <= acc_sum;
      end
      if (state == DRAIN) mac_q <= acc_sum;
      if (iEnSample && ((state == RUN) || (state == DRAIN))) overrun_q <= 1'b1;
    end
  end

endmodule
